// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants, state encoding and divider helper for the UART
//          transmit path.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // FSM state encoding, also driven out on the debug state port
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  // Clocks per bit, truncated
  function automatic int calc_div(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : baud_tick_gen
// Brief  : Free-running 0..DIV-1 bit-period counter with synchronous clear.
//          tick_o is high for the last clock of every bit period.
// Rev    : 1.0  initial release
// ============================================================================
module baud_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: hold at zero while cleared, wrap after the last clock of a period
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_tx_serializer
// Brief  : Valid/ready byte input, one-byte holding register and a framing
//          FSM that drives a registered, idle-high UART TX line.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 9600000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx_ready,
  output logic       RsTx,
  output logic       busy,
  output logic [2:0] state
);

  localparam int         DIV       = calc_div(CLK_RATE, BAUD_RATE);
  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rstx_q, rstx_d;

  logic       tick;
  logic       accept;
  logic       load;

  // Bit-period timer, parked at zero while idle so START gets a full period
  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == S_IDLE),
    .tick_o  (tick)
  );

  // Next-state, holding/shift register updates and registered line level
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;
    accept      = data_valid && tx_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            bit_cnt_d = 3'd0;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d   = S_STOP;
          bit_cnt_d = 3'd0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            // Chain straight into the next frame when a byte is waiting
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Transfer latches the masked payload and its parity together
    if (load) begin
      shift_d     = hold_q & DATA_MASK;
      par_d       = (^(hold_q & DATA_MASK)) ^ PAR_INV;
      hold_full_d = 1'b0;
      bit_cnt_d   = 3'd0;
    end

    // Accept only while empty, so it never collides with a transfer
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    tx_ready_d = !hold_full_d;

    unique case (state_d)
      S_IDLE:   rstx_d = 1'b1;
      S_START:  rstx_d = 1'b0;
      S_DATA:   rstx_d = shift_d[0];
      S_PARITY: rstx_d = par_d;
      S_STOP:   rstx_d = 1'b1;
      default:  rstx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame and idles the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rstx_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      rstx_q      <= rstx_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign RsTx     = rstx_q;
  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-to-serial UART transmitter: accepts bytes on a valid/ready handshake and drives an 8N1 (configurable parity/stop) frame on the TX line. It runs its own baud counter from the 9.6 MHz system clock, so it needs no external `uart_clk`. It has a one-byte holding register so upstream processing can queue the next byte while the current frame shifts out. It pairs with the sampled receiver path and feeds the board TX pin.

## Interface
- `CLK_RATE`, 9600000: system clock frequency, Hz.
- `BAUD_RATE`, 9600: line rate, bits/s. `DIV = CLK_RATE/BAUD_RATE` (integer, truncated); legal range `DIV >= 2`.
- `DATA_BITS`, 8: payload bits per frame; legal range 5–8.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `data_in` in 8: byte to send. Bits above `DATA_BITS-1` are ignored.
- `data_valid` in 1: `data_in` is valid.
- `tx_ready` out 1: holding register is empty. A byte is accepted on an edge where `data_valid && tx_ready`.
- `RsTx` out 1: serial line, registered, idle high.
- `busy` out 1: a frame is being shifted out (state ≠ IDLE).
- `state` out 3: current FSM state, for debug LEDs.

## Operation
- Reset (`rst`=0, takes effect immediately): `RsTx`=1, `tx_ready`=1, `busy`=0, `state`=IDLE (0). The holding register, shift register, baud counter and bit counter are cleared. A frame in progress is abandoned and the line returns to high.
- Holding register:
  - Loaded on accept; this sets `hold_full`.
  - `tx_ready = !hold_full`, registered.
  - Emptied when its contents move to the shift register.
  - Because `tx_ready` is 0 whenever the register is full, accept and transfer can never occur on the same edge.
- FSM states, with `state` encoding:
  - IDLE (0): `RsTx`=1. If `hold_full`, transfer the byte to the shift register, then go to START.
  - START (1): `RsTx`=0 for `DIV` clocks, then go to DATA.
  - DATA (2): `RsTx` = shift register bit 0, LSB first. Shift right each bit period. After `DATA_BITS` periods go to PARITY if `PARITY`≠0, else STOP.
  - PARITY (3): `RsTx` = XOR of the payload bits for even parity, inverted for odd. Lasts `DIV` clocks, then go to STOP.
  - STOP (4): `RsTx`=1 for `STOP_BITS*DIV` clocks. At the end, if `hold_full`, transfer the byte and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..`DIV-1` and holds at 0 in IDLE.
  - Every bit period is exactly `DIV` clocks, measured from the edge that enters START.
  - Width is `$clog2(DIV)`.
- Parity is computed from the shift-register contents latched at transfer. Changes on `data_in` after accept have no effect.
- `data_valid` while `tx_ready`=0 is ignored; no byte is accepted and no error is flagged.

## Timing
- Accept at edge T gives `tx_ready`=0 from T.
- From IDLE: the transfer happens at T+1, which gives `RsTx`=0, `state`=START and `tx_ready`=1, all visible after T+1. Latency from accept to the start bit is 1 clock.
- Frame length: `DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)` clocks, measured from the edge entering START.
- Back-to-back bytes: the next start bit begins on the clock immediately after the last stop-bit clock. The line has zero idle time.
- `busy` and `state` change on the same edge as the `RsTx` transitions.

## Structure
- Shared package `uart_pkg`:
  - State encoding localparams (`ST_IDLE`..`ST_STOP`).
  - Parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`).
  - `DIV` computation function.
- Sub-module `baud_tick_gen`: DIV counter with synchronous `clear`, outputs a one-clock `tick` when the count reaches `DIV-1`.
- Top-level FSM, holding register and shift register live in `uart_tx_serializer`.

## Test plan
Bench parameters: `CLK_RATE`=153600, `BAUD_RATE`=9600, so `DIV`=16.

1. Reset: assert `rst`=0 mid-frame, in the DATA state. Required: `RsTx`=1, `state`=0 and `tx_ready`=1 immediately; no further line activity after release.
2. Single byte 0x55, 8N1: the line reads 0,1,0,1,0,1,0,1,0,1, each level 16 clocks; total 160 clocks; start bit 1 clock after accept; `busy` 0→1→0.
3. Back-to-back 0xA3 then 0x0F, with the second byte accepted during the first frame's DATA state: 320 contiguous clocks with no idle gap; each frame decodes correctly; `tx_ready` stays 0 from the second accept until the second frame's START.
4. `PARITY`=1 with 0x07: parity bit = 1. `PARITY`=2 with 0x07: parity bit = 0. 8E1 frame = 176 clocks.
5. `STOP_BITS`=2, `DATA_BITS`=7, byte 0xFF: bit 7 is ignored; 7 payload bits of 1; stop high for 32 clocks; frame = 160 clocks.
6. `data_valid` held high with `data_in` changing every clock while `tx_ready`=0: only bytes sampled on edges with `tx_ready`=1 appear on the line, in order.
